dm_access_arbiter: RTL and testbench

- Sequences all accesses to the 256x8 data memory and shares it between two requesters.
  - Port 0: pipeline DM stage (load/store).
  - Port 1: debug/loader port, used for program-data preload and memory dump.
- Round-robin arbitration, registered memory drive, fixed 3-cycle request-to-ack latency.
- Stalls the pipeline while its request is pending.
- Write-protects a low address window against port 1.

---
 rtl/dm_access_arbiter.sv | 163 ++++++++++++++++
 tb/tb_dm_access_arbiter.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_access_arbiter.sv
// Round-robin arbiter sharing a synchronous data memory between the pipeline (port 0)
// and the debug/loader port (port 1), with a fixed IDLE -> ACCESS -> RESP sequence.
module dm_access_arbiter #(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 8,
  parameter logic [ADDR_W-1:0] PROT_TOP = ADDR_W'('h0F)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              stall_p0
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic              supp_q, supp_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              p0_ack_q, p0_ack_d;
  logic              p1_ack_q, p1_ack_d;
  logic              p1_err_q, p1_err_d;
  logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
  logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;

  logic              elig0, elig1, gnt1;
  logic              sel_we, sel_supp;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // A port whose ack is showing this cycle is masked, so the other port can be
  // granted in the ack cycle and contending ports alternate without gaps.
  assign elig0     = p0_req & ~p0_ack_q;
  assign elig1     = p1_req & ~p1_ack_q;
  assign gnt1      = elig1 & (~elig0 | ~last_grant_q);
  assign sel_we    = gnt1 ? p1_we    : p0_we;
  assign sel_addr  = gnt1 ? p1_addr  : p0_addr;
  assign sel_wdata = gnt1 ? p1_wdata : p0_wdata;
  assign sel_supp  = gnt1 & sel_we & (sel_addr <= PROT_TOP);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    we_d         = we_q;
    supp_d       = supp_q;
    mem_en_d     = mem_en_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    p0_ack_d     = 1'b0;
    p1_ack_d     = 1'b0;
    p1_err_d     = 1'b0;
    p0_rdata_d   = p0_rdata_q;
    p1_rdata_d   = p1_rdata_q;
    case (state_q)
      IDLE: begin
        if (elig0 | elig1) begin
          owner_d      = gnt1;
          we_d         = sel_we;
          supp_d       = sel_supp;
          last_grant_d = gnt1;
          mem_en_d     = 1'b1;
          mem_we_d     = sel_we & ~sel_supp;
          mem_addr_d   = sel_addr;
          mem_wdata_d  = sel_wdata;
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
        state_d  = RESP;
      end
      RESP: begin
        state_d = IDLE;
        if (owner_q) begin
          p1_ack_d = 1'b1;
          p1_err_d = supp_q;
          if (!we_q) p1_rdata_d = mem_rdata;
        end else begin
          p0_ack_d = 1'b1;
          if (!we_q) p0_rdata_d = mem_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      supp_q       <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      p0_ack_q     <= 1'b0;
      p1_ack_q     <= 1'b0;
      p1_err_q     <= 1'b0;
      p0_rdata_q   <= '0;
      p1_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      supp_q       <= supp_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      p0_ack_q     <= p0_ack_d;
      p1_ack_q     <= p1_ack_d;
      p1_err_q     <= p1_err_d;
      p0_rdata_q   <= p0_rdata_d;
      p1_rdata_q   <= p1_rdata_d;
    end
  end

  assign p0_ack    = p0_ack_q;
  assign p1_ack    = p1_ack_q;
  assign p1_err    = p1_err_q;
  assign p0_rdata  = p0_rdata_q;
  assign p1_rdata  = p1_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != IDLE);
  assign stall_p0  = p0_req & ~p0_ack_q;

endmodule

// File: tb/tb_dm_access_arbiter.sv
// Bench for dm_access_arbiter: behavioural 256x8 memory, transaction-level reference
// memory, and one task per scenario.
module tb_dm_access_arbiter;

  localparam logic [7:0] PROT = 8'h0F;

  logic       clk;
  logic       rst;
  logic       p0_req, p0_we, p1_req, p1_we;
  logic [7:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic       p0_ack, p1_ack, p1_err;
  logic [7:0] p0_rdata, p1_rdata;
  logic       mem_en, mem_we;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       busy, stall_p0;

  logic       mem_clr;
  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];

  int checks;
  int failures;

  // contention bookkeeping: the op currently on each port's inputs
  logic       cur_we [2];
  logic [7:0] cur_addr [2];
  logic [7:0] cur_wd [2];

  dm_access_arbiter dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .stall_p0(stall_p0)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // synchronous memory: read data valid the cycle after mem_en
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem_rdata <= 8'h00;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic suppressed(input int port, input logic we, input logic [7:0] addr);
    return (port == 1) && we && (addr <= PROT);
  endfunction

  function automatic logic [7:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return 8'($urandom_range(0, 31));
    return 8'($urandom_range(0, 255));
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; mem_clr = 1'b1;
    p0_req = 1'b0; p0_we = 1'b0; p0_addr = 8'h00; p0_wdata = 8'h00;
    p1_req = 1'b0; p1_we = 1'b0; p1_addr = 8'h00; p1_wdata = 8'h00;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    next_cycle();
    next_cycle();
    rst = 1'b0; mem_clr = 1'b0;
  endtask

  // driver: one transaction on one port, starting this cycle (cycle 0)
  task automatic run_txn(input int port, input logic we, input logic [7:0] addr,
                         input logic [7:0] wd, output int ack_cyc, output logic [7:0] rd,
                         output logic err, output int en_cyc, output logic we_seen);
    ack_cyc = -1; en_cyc = -1; we_seen = 1'b0; rd = 8'h00; err = 1'b0;
    if (port == 0) begin
      p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wd;
    end else begin
      p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wd;
    end
    for (int c = 0; c < 20 && ack_cyc < 0; c++) begin
      @(negedge clk);
      if (mem_en && en_cyc < 0) en_cyc = c;
      if (mem_we) we_seen = 1'b1;
      if ((port == 0) ? p0_ack : p1_ack) begin
        ack_cyc = c;
        rd = (port == 0) ? p0_rdata : p1_rdata;
        err = p1_err;
      end
      next_cycle();
    end
    p0_req = 1'b0; p1_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; p0_req = 1'b1; p1_req = 1'b1; p0_we = 1'b1; p1_we = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    checks++;
    if ({p0_ack, p1_ack, p1_err, busy} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags: got ack0/ack1/err/busy=%b required 0000", {p0_ack, p1_ack, p1_err, busy});
    end
    checks++;
    if ({mem_en, mem_we, mem_addr, mem_wdata} !== 18'h0) begin
      failures++;
      $display("FAIL reset_mem: got en=%b we=%b addr=%h wd=%h required all 0", mem_en, mem_we, mem_addr, mem_wdata);
    end
    checks++;
    if ({p0_rdata, p1_rdata} !== 16'h0) begin
      failures++;
      $display("FAIL reset_rdata: got %h/%h required 00/00", p0_rdata, p1_rdata);
    end
    do_reset();
  endtask

  task automatic test_single_read();
    int ack_c, en_c; logic [7:0] rd; logic err, wes, exp_st;
    do_reset();
    run_txn(1, 1'b1, 8'h20, 8'hA5, ack_c, rd, err, en_c, wes);
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 8'h20; p0_wdata = 8'h00;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      exp_st = (c < 3);
      checks++;
      if (stall_p0 !== exp_st) begin
        failures++;
        $display("FAIL single_stall c%0d: got %b required %b", c, stall_p0, exp_st);
      end
      if (c == 1) begin
        checks++;
        if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 8'h20) begin
          failures++;
          $display("FAIL single_mem_drive: got en=%b we=%b addr=%h required 1 0 20", mem_en, mem_we, mem_addr);
        end
      end
      if (c == 3) begin
        checks++;
        if (p0_ack !== 1'b1 || p0_rdata !== 8'hA5) begin
          failures++;
          $display("FAIL single_ack: got ack=%b rdata=%h required 1 a5", p0_ack, p0_rdata);
        end
      end
      next_cycle();
    end
    p0_req = 1'b0;
    next_cycle();
  endtask

  task automatic test_simultaneous();
    int a0, a1, ack_c, en_c; logic g1; logic [7:0] rd; logic err, wes;
    do_reset();
    a0 = -1; a1 = -1; g1 = 1'b0;
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 8'h40; p0_wdata = 8'h11;
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 8'h41; p1_wdata = 8'h22;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (p0_ack && a0 < 0) a0 = c;
      if (p1_ack && a1 < 0) a1 = c;
      if (c == 4) g1 = mem_en && mem_we && (mem_addr == 8'h41);
      next_cycle();
      if (a0 >= 0) p0_req = 1'b0;
      if (a1 >= 0) p1_req = 1'b0;
    end
    checks++;
    if (a0 != 3) begin failures++; $display("FAIL simul_p0_ack: got cycle %0d required 3", a0); end
    checks++;
    if (g1 !== 1'b1) begin failures++; $display("FAIL simul_p1_grant: got drive=%b in cycle 4 required 1", g1); end
    checks++;
    if (a1 != 6) begin failures++; $display("FAIL simul_p1_ack: got cycle %0d required 6", a1); end
    run_txn(0, 1'b0, 8'h40, 8'h00, ack_c, rd, err, en_c, wes);
    checks++;
    if (rd !== 8'h11) begin failures++; $display("FAIL simul_read40: got %h required 11", rd); end
    run_txn(0, 1'b0, 8'h41, 8'h00, ack_c, rd, err, en_c, wes);
    checks++;
    if (rd !== 8'h22) begin failures++; $display("FAIL simul_read41: got %h required 22", rd); end
  endtask

  task automatic pick_op(input int p);
    cur_we[p]   = 1'($urandom_range(0, 1));
    cur_addr[p] = rand_addr();
    cur_wd[p]   = 8'($urandom_range(0, 255));
    if (p == 0) begin
      p0_we = cur_we[0]; p0_addr = cur_addr[0]; p0_wdata = cur_wd[0];
    end else begin
      p1_we = cur_we[1]; p1_addr = cur_addr[1]; p1_wdata = cur_wd[1];
    end
  endtask

  // scoreboard: expected grant order, ack spacing, read data and err per ack
  task automatic test_contention(input int n);
    logic [0:0] exp_q[$];
    logic [0:0] got_port, ep;
    logic       dwe [2];
    logic [7:0] daddr [2];
    logic [7:0] dwd [2];
    logic [7:0] rd;
    logic       e_err;
    int done, np;
    do_reset();
    for (int i = 0; i < n; i++) exp_q.push_back(1'(i % 2));
    pick_op(0); pick_op(1);
    p0_req = 1'b1; p1_req = 1'b1;
    done = 0;
    for (int c = 0; c < 3 * n + 12 && done < n; c++) begin
      if (p0_ack) begin dwe[0] = cur_we[0]; daddr[0] = cur_addr[0]; dwd[0] = cur_wd[0]; pick_op(0); end
      if (p1_ack) begin dwe[1] = cur_we[1]; daddr[1] = cur_addr[1]; dwd[1] = cur_wd[1]; pick_op(1); end
      @(negedge clk);
      if (p0_ack || p1_ack) begin
        checks++;
        if (p0_ack && p1_ack) begin failures++; $display("FAIL cont_dual_ack: both acks high in cycle %0d", c); end
        got_port = p1_ack;
        ep = exp_q.pop_front();
        checks++;
        if (got_port !== ep) begin failures++; $display("FAIL cont_order #%0d: got port %0d required %0d", done, got_port, ep); end
        checks++;
        if (c != 3 * (done + 1)) begin failures++; $display("FAIL cont_timing #%0d: got cycle %0d required %0d", done, c, 3 * (done + 1)); end
        np = int'(got_port);
        e_err = suppressed(np, dwe[np], daddr[np]);
        checks++;
        if (p1_err !== e_err) begin failures++; $display("FAIL cont_err #%0d: got %b required %b", done, p1_err, e_err); end
        if (!dwe[np]) begin
          rd = (np == 1) ? p1_rdata : p0_rdata;
          checks++;
          if (rd !== ref_mem[daddr[np]]) begin
            failures++;
            $display("FAIL cont_rdata #%0d: got %h required %h", done, rd, ref_mem[daddr[np]]);
          end
        end else if (!e_err) begin
          ref_mem[daddr[np]] = dwd[np];
        end
        done++;
      end
      next_cycle();
    end
    checks++;
    if (done != n) begin failures++; $display("FAIL cont_timeout: got %0d acks required %0d", done, n); end
    p0_req = 1'b0; p1_req = 1'b0;
    for (int i = 0; i < 5; i++) next_cycle();
  endtask

  task automatic test_protect();
    int ack_c, en_c; logic [7:0] rd; logic err, wes;
    do_reset();
    run_txn(0, 1'b1, 8'h05, 8'h5A, ack_c, rd, err, en_c, wes);
    checks++;
    if (ack_c != 3 || err !== 1'b0 || wes !== 1'b1) begin
      failures++;
      $display("FAIL prot_p0_write: got ack=%0d err=%b we=%b required 3 0 1", ack_c, err, wes);
    end
    run_txn(1, 1'b1, 8'h05, 8'hFF, ack_c, rd, err, en_c, wes);
    checks++;
    if (ack_c != 3 || err !== 1'b1 || wes !== 1'b0) begin
      failures++;
      $display("FAIL prot_p1_write: got ack=%0d err=%b we=%b required 3 1 0", ack_c, err, wes);
    end
    run_txn(0, 1'b0, 8'h05, 8'h00, ack_c, rd, err, en_c, wes);
    checks++;
    if (rd !== 8'h5A) begin failures++; $display("FAIL prot_readback: got %h required 5a", rd); end
    run_txn(1, 1'b1, PROT, 8'h33, ack_c, rd, err, en_c, wes);
    checks++;
    if (err !== 1'b1 || wes !== 1'b0) begin failures++; $display("FAIL prot_top_edge: got err=%b we=%b required 1 0", err, wes); end
    run_txn(1, 1'b1, PROT + 8'h01, 8'h44, ack_c, rd, err, en_c, wes);
    checks++;
    if (err !== 1'b0 || wes !== 1'b1) begin failures++; $display("FAIL prot_above_edge: got err=%b we=%b required 0 1", err, wes); end
    run_txn(1, 1'b0, 8'h00, 8'h00, ack_c, rd, err, en_c, wes);
    checks++;
    if (err !== 1'b0 || rd !== 8'h00) begin failures++; $display("FAIL prot_p1_read: got err=%b rd=%h required 0 00", err, rd); end
  endtask

  task automatic test_back_to_back();
    int acks[$];
    int ens[$];
    int ack_c, en_c, nack; logic [7:0] rd, rd1; logic err, wes, prev_en;
    do_reset();
    run_txn(1, 1'b1, 8'h30, 8'h77, ack_c, rd, err, en_c, wes);
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 8'h30; p0_wdata = 8'h00;
    nack = 0; prev_en = 1'b0; rd1 = 8'h00;
    for (int c = 0; c < 12; c++) begin
      if (p0_ack) begin
        nack++;
        if (nack == 1) begin p0_we = 1'b1; p0_addr = 8'h31; p0_wdata = 8'h99; end
        else p0_req = 1'b0;
      end
      @(negedge clk);
      if (mem_en && !prev_en) ens.push_back(c);
      prev_en = mem_en;
      if (p0_ack) begin
        acks.push_back(c);
        if (acks.size() == 1) rd1 = p0_rdata;
      end
      next_cycle();
    end
    p0_req = 1'b0;
    checks++;
    if (acks.size() != 2 || acks[0] != 3 || acks[1] != 7) begin
      failures++;
      $display("FAIL b2b_acks: got %0d acks first=%0d required 2 acks at 3 and 7", acks.size(), (acks.size() > 0) ? acks[0] : -1);
    end
    checks++;
    if (ens.size() != 2 || ens[1] != 5) begin
      failures++;
      $display("FAIL b2b_mem_en: got %0d strobes second=%0d required 2 with second at 5", ens.size(), (ens.size() > 1) ? ens[1] : -1);
    end
    checks++;
    if (rd1 !== 8'h77) begin failures++; $display("FAIL b2b_rdata: got %h required 77", rd1); end
    run_txn(1, 1'b0, 8'h31, 8'h00, ack_c, rd, err, en_c, wes);
    checks++;
    if (rd !== 8'h99) begin failures++; $display("FAIL b2b_readback: got %h required 99", rd); end
  endtask

  task automatic test_reset_mid();
    int ack_c, en_c; logic [7:0] rd; logic err, wes;
    do_reset();
    run_txn(0, 1'b1, 8'h60, 8'hC3, ack_c, rd, err, en_c, wes);
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 8'h60; p1_wdata = 8'h00;
    next_cycle();
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL rmid_busy_resp: got %b required 1", busy); end
    next_cycle();
    rst = 1'b0; p1_req = 1'b0;
    @(negedge clk);
    checks++;
    if (p1_ack !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rmid_no_ack: got ack=%b busy=%b required 0 0", p1_ack, busy);
    end
    checks++;
    if ({mem_en, mem_we, mem_addr, mem_wdata} !== 18'h0) begin
      failures++;
      $display("FAIL rmid_mem: got en=%b we=%b addr=%h wd=%h required all 0", mem_en, mem_we, mem_addr, mem_wdata);
    end
    next_cycle();
    run_txn(0, 1'b0, 8'h60, 8'h00, ack_c, rd, err, en_c, wes);
    checks++;
    if (ack_c != 3 || rd !== 8'hC3) begin
      failures++;
      $display("FAIL rmid_after: got ack=%0d rd=%h required 3 c3", ack_c, rd);
    end
  endtask

  task automatic test_random_single(input int n);
    int ack_c, en_c, port; logic [7:0] rd, addr, wd, exp_rd; logic err, wes, we, e_err;
    do_reset();
    for (int i = 0; i < n; i++) begin
      port = $urandom_range(0, 1);
      we = 1'($urandom_range(0, 1));
      addr = rand_addr();
      wd = 8'($urandom_range(0, 255));
      e_err = suppressed(port, we, addr);
      exp_rd = ref_mem[addr];
      run_txn(port, we, addr, wd, ack_c, rd, err, en_c, wes);
      checks++;
      if (ack_c != 3 || en_c != 1) begin
        failures++;
        $display("FAIL rand_latency #%0d: got ack=%0d en=%0d required 3 1", i, ack_c, en_c);
      end
      checks++;
      if (err !== e_err || wes !== (we & ~e_err)) begin
        failures++;
        $display("FAIL rand_err #%0d: got err=%b we=%b required %b %b", i, err, wes, e_err, we & ~e_err);
      end
      if (!we) begin
        checks++;
        if (rd !== exp_rd) begin failures++; $display("FAIL rand_rdata #%0d: got %h required %h", i, rd, exp_rd); end
      end else if (!e_err) begin
        ref_mem[addr] = wd;
      end
    end
  endtask

  initial begin
    checks = 0; failures = 0; mem_clr = 1'b1; rst = 1'b1;
    p0_req = 1'b0; p0_we = 1'b0; p0_addr = 8'h00; p0_wdata = 8'h00;
    p1_req = 1'b0; p1_we = 1'b0; p1_addr = 8'h00; p1_wdata = 8'h00;
    test_reset();
    test_single_read();
    test_simultaneous();
    test_contention(8);
    test_protect();
    test_back_to_back();
    test_reset_mid();
    test_contention(40);
    test_random_single(60);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
